// File: rtl/apb_equivalence_checker.sv
// Purpose : compares N APB slave responses to one shared request against DUT 0.
// Latency : pready_o is combinational; the verdict (cmp_valid) follows one cycle after pready_o.
// Backpres: pready_o holds the master until every DUT has completed or the skew limit aborts.
//
// Ports
//   PCLK, PRESETn          clock, async active-low reset
//   PSEL/PENABLE/PWRITE    shared master request; PADDR shared address
//   dut_pready/prdata/pslverr  per-DUT responses, DUT i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   pready_o               combined ready back to the master
//   cmp_valid/mismatch/mismatch_mask  one-cycle verdict
//   timeout/proto_err      one-cycle abort pulses
//   err_sticky, xfer_cnt, mismatch_cnt, first_fail_addr  bench-facing status
`timescale 1ns/1ps
module apb_equivalence_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_DUTS   = 2,
    parameter int MAX_SKEW   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [NUM_DUTS-1:0]            dut_pready,
    input  logic [NUM_DUTS*DATA_WIDTH-1:0] dut_prdata,
    input  logic [NUM_DUTS-1:0]            dut_pslverr,
    output logic                           pready_o,
    output logic                           cmp_valid,
    output logic                           mismatch,
    output logic [NUM_DUTS-1:0]            mismatch_mask,
    output logic                           timeout,
    output logic                           proto_err,
    output logic                           err_sticky,
    output logic [CNT_WIDTH-1:0]           xfer_cnt,
    output logic [CNT_WIDTH-1:0]           mismatch_cnt,
    output logic [ADDR_WIDTH-1:0]          first_fail_addr
);

    localparam logic [7:0] SKEW_LIM = 8'(MAX_SKEW);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    state_t                                 state_q, state_d;
    logic [NUM_DUTS-1:0]                    done_q, done_d;
    logic [NUM_DUTS-1:0][DATA_WIDTH-1:0]    data_q, data_d;
    logic [NUM_DUTS-1:0]                    err_q, err_d;
    logic                                   pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]                  addr_q, addr_d;
    logic [7:0]                             skew_q, skew_d;
    logic                                   abort_q, abort_d;
    logic [NUM_DUTS-1:0]                    abort_mask_q, abort_mask_d;
    logic [CNT_WIDTH-1:0]                   xfer_cnt_q, xfer_cnt_d;
    logic [CNT_WIDTH-1:0]                   mismatch_cnt_q, mismatch_cnt_d;
    logic                                   err_sticky_q, err_sticky_d;
    logic                                   fail_seen_q, fail_seen_d;
    logic [ADDR_WIDTH-1:0]                  first_fail_addr_q, first_fail_addr_d;

    logic                                   access;
    logic [NUM_DUTS-1:0]                    completing;
    logic [NUM_DUTS-1:0]                    done_now;
    logic                                   all_now;
    logic                                   started;
    logic [NUM_DUTS-1:0]                    cmp_mask;
    logic [NUM_DUTS-1:0]                    report_mask;

    // Response comparison against the golden channel, from captured data.
    // PRDATA only matters on reads where both sides agree on PSLVERR.
    always_comb begin
        cmp_mask = '0;
        for (int i = 1; i < NUM_DUTS; i++) begin
            if (err_q[i] != err_q[0]) begin
                cmp_mask[i] = 1'b1;
            end else if (!pwrite_q && (data_q[i] != data_q[0])) begin
                cmp_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        done_d            = done_q;
        data_d            = data_q;
        err_d             = err_q;
        pwrite_d          = pwrite_q;
        addr_d            = addr_q;
        skew_d            = skew_q;
        abort_d           = abort_q;
        abort_mask_d      = abort_mask_q;
        xfer_cnt_d        = xfer_cnt_q;
        mismatch_cnt_d    = mismatch_cnt_q;
        err_sticky_d      = err_sticky_q;
        fail_seen_d       = fail_seen_q;
        first_fail_addr_d = first_fail_addr_q;
        pready_o          = 1'b0;
        cmp_valid         = 1'b0;
        mismatch          = 1'b0;
        mismatch_mask     = '0;
        timeout           = 1'b0;
        proto_err         = 1'b0;
        report_mask       = '0;

        access = PSEL && PENABLE;
        // REPORT never captures: a request arriving there is left for the next IDLE.
        if (access && (state_q != ST_REPORT)) begin
            completing = dut_pready & ~done_q;
        end else begin
            completing = '0;
        end
        done_now = done_q | completing;
        all_now  = &done_now;
        started  = |done_now;

        for (int i = 0; i < NUM_DUTS; i++) begin
            if (completing[i]) begin
                data_d[i] = dut_prdata[i*DATA_WIDTH +: DATA_WIDTH];
                err_d[i]  = dut_pslverr[i];
            end
        end
        done_d = done_now;

        case (state_q)
            ST_IDLE: begin
                skew_d       = '0;
                abort_d      = 1'b0;
                abort_mask_d = '0;
                if (access) begin
                    pwrite_d = PWRITE;
                    addr_d   = PADDR;
                    if (all_now) begin
                        pready_o = 1'b1;
                        state_d  = ST_REPORT;
                    end else begin
                        state_d = ST_COLLECT;
                        // Skew is measured from the first completion, which may be this cycle.
                        if (started) begin
                            skew_d = 8'd1;
                        end
                    end
                end
            end

            ST_COLLECT: begin
                if (!PSEL) begin
                    proto_err    = 1'b1;
                    abort_d      = 1'b1;
                    abort_mask_d = '1;
                    err_sticky_d = 1'b1;
                    state_d      = ST_REPORT;
                end else if (access && all_now) begin
                    // Completion takes priority over a skew limit reached in the same cycle.
                    pready_o = 1'b1;
                    state_d  = ST_REPORT;
                end else if (skew_q == SKEW_LIM) begin
                    timeout      = 1'b1;
                    pready_o     = 1'b1;
                    abort_d      = 1'b1;
                    abort_mask_d = ~done_now;
                    err_sticky_d = 1'b1;
                    state_d      = ST_REPORT;
                end else if (started) begin
                    skew_d = skew_q + 8'd1;
                end
            end

            ST_REPORT: begin
                cmp_valid     = 1'b1;
                report_mask   = abort_q ? abort_mask_q : cmp_mask;
                mismatch_mask = report_mask;
                mismatch      = |report_mask;
                if (xfer_cnt_q != '1) begin
                    xfer_cnt_d = xfer_cnt_q + CNT_WIDTH'(1);
                end
                if (mismatch) begin
                    err_sticky_d = 1'b1;
                    if (mismatch_cnt_q != '1) begin
                        mismatch_cnt_d = mismatch_cnt_q + CNT_WIDTH'(1);
                    end
                    if (!fail_seen_q) begin
                        fail_seen_d       = 1'b1;
                        first_fail_addr_d = addr_q;
                    end
                end
                done_d  = '0;
                skew_d  = '0;
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                done_d  = '0;
                skew_d  = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q           <= ST_IDLE;
            done_q            <= '0;
            data_q            <= '0;
            err_q             <= '0;
            pwrite_q          <= 1'b0;
            addr_q            <= '0;
            skew_q            <= '0;
            abort_q           <= 1'b0;
            abort_mask_q      <= '0;
            xfer_cnt_q        <= '0;
            mismatch_cnt_q    <= '0;
            err_sticky_q      <= 1'b0;
            fail_seen_q       <= 1'b0;
            first_fail_addr_q <= '0;
        end else begin
            state_q           <= state_d;
            done_q            <= done_d;
            data_q            <= data_d;
            err_q             <= err_d;
            pwrite_q          <= pwrite_d;
            addr_q            <= addr_d;
            skew_q            <= skew_d;
            abort_q           <= abort_d;
            abort_mask_q      <= abort_mask_d;
            xfer_cnt_q        <= xfer_cnt_d;
            mismatch_cnt_q    <= mismatch_cnt_d;
            err_sticky_q      <= err_sticky_d;
            fail_seen_q       <= fail_seen_d;
            first_fail_addr_q <= first_fail_addr_d;
        end
    end

    assign err_sticky      = err_sticky_q;
    assign xfer_cnt        = xfer_cnt_q;
    assign mismatch_cnt    = mismatch_cnt_q;
    assign first_fail_addr = first_fail_addr_q;

endmodule

// File: tb/tb_apb_equivalence_checker.sv
// Purpose : directed checks of apb_equivalence_checker with 2-DUT and 3-DUT instances.
// Latency : inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpres: the bench master follows pready_o by schedule; every wait is a fixed cycle count.
`timescale 1ns/1ps
module tb_apb_equivalence_checker;

    logic        clk = 1'b0;
    logic        presetn = 1'b0;
    logic        pwrite = 1'b0;
    logic [11:0] paddr = '0;

    // 2-DUT instance signals
    logic        psel = 1'b0, penable = 1'b0;
    logic [1:0]  rdy2 = '0, err2 = '0;
    logic [63:0] prdata2 = '0;
    logic        pready_o2, cmp_valid2, mismatch2, timeout2, proto_err2, err_sticky2;
    logic [1:0]  mask2;
    logic [15:0] xfer_cnt2, mm_cnt2;
    logic [11:0] ffa2;

    // 3-DUT instance signals
    logic        psel3 = 1'b0, penable3 = 1'b0;
    logic [2:0]  rdy3 = '0, err3 = '0;
    logic [95:0] prdata3 = '0;
    logic        pready_o3, cmp_valid3, mismatch3, timeout3, proto_err3, err_sticky3;
    logic [2:0]  mask3;
    logic [15:0] xfer_cnt3, mm_cnt3;
    logic [11:0] ffa3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    apb_equivalence_checker #(
        .DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_DUTS(2), .MAX_SKEW(4), .CNT_WIDTH(16)
    ) u_dut2 (
        .PCLK(clk), .PRESETn(presetn), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .dut_pready(rdy2), .dut_prdata(prdata2), .dut_pslverr(err2),
        .pready_o(pready_o2), .cmp_valid(cmp_valid2), .mismatch(mismatch2),
        .mismatch_mask(mask2), .timeout(timeout2), .proto_err(proto_err2),
        .err_sticky(err_sticky2), .xfer_cnt(xfer_cnt2), .mismatch_cnt(mm_cnt2),
        .first_fail_addr(ffa2)
    );

    apb_equivalence_checker #(
        .DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_DUTS(3), .MAX_SKEW(4), .CNT_WIDTH(16)
    ) u_dut3 (
        .PCLK(clk), .PRESETn(presetn), .PSEL(psel3), .PENABLE(penable3), .PWRITE(pwrite),
        .PADDR(paddr), .dut_pready(rdy3), .dut_prdata(prdata3), .dut_pslverr(err3),
        .pready_o(pready_o3), .cmp_valid(cmp_valid3), .mismatch(mismatch3),
        .mismatch_mask(mask3), .timeout(timeout3), .proto_err(proto_err3),
        .err_sticky(err_sticky3), .xfer_cnt(xfer_cnt3), .mismatch_cnt(mm_cnt3),
        .first_fail_addr(ffa3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // 2-DUT transfer where both DUTs answer in the first access cycle.
    // Returns at the REPORT-cycle sample point.
    task automatic xfer2(input string tag, input logic [11:0] a, input logic wr,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic e0, input logic e1);
        cyc(); psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; rdy2 = 2'b00;
        cyc(); penable = 1'b1; rdy2 = 2'b11; prdata2 = {d1, d0}; err2 = {e1, e0};
        smp(); chk({tag, "_pready"}, 64'(pready_o2), 64'd1);
        cyc(); psel = 1'b0; penable = 1'b0; rdy2 = 2'b00; err2 = 2'b00;
        smp(); chk({tag, "_cmp_valid"}, 64'(cmp_valid2), 64'd1);
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (2) cyc();
        smp();
        chk("rst_pready",   64'(pready_o2),  64'd0);
        chk("rst_cmp",      64'(cmp_valid2), 64'd0);
        chk("rst_mismatch", 64'(mismatch2),  64'd0);
        chk("rst_mask",     64'(mask2),      64'd0);
        chk("rst_sticky",   64'(err_sticky2), 64'd0);
        chk("rst_xfer",     64'(xfer_cnt2),  64'd0);
        chk("rst_ffa",      64'(ffa2),       64'd0);
        chk("rst3_outs", {cmp_valid3, mismatch3, mask3, timeout3, proto_err3, err_sticky3, pready_o3},
            64'd0);
        chk("rst3_cnts", {xfer_cnt3, mm_cnt3, ffa3}, 64'd0);
        presetn = 1'b1;

        // ---------------- equal read, both ready together ----------------
        xfer2("eq_rd", 12'h100, 1'b0, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 1'b0);
        chk("eq_rd_mismatch", 64'(mismatch2), 64'd0);
        chk("eq_rd_mask",     64'(mask2),     64'd0);
        cyc(); smp();
        chk("eq_rd_cmp_gone", 64'(cmp_valid2), 64'd0);
        chk("eq_rd_xfer",     64'(xfer_cnt2),  64'd1);

        // ---------------- read data mismatch ----------------
        xfer2("mm_rd", 12'h2C4, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("mm_rd_mismatch", 64'(mismatch2), 64'd1);
        chk("mm_rd_mask",     64'(mask2),     64'h2);
        cyc(); smp();
        chk("mm_rd_mmcnt",  64'(mm_cnt2),     64'd1);
        chk("mm_rd_sticky", 64'(err_sticky2), 64'd1);
        chk("mm_rd_ffa",    64'(ffa2),        64'h2C4);
        chk("mm_rd_xfer",   64'(xfer_cnt2),   64'd2);

        // ---------------- writes ----------------
        xfer2("wr_data", 12'h010, 1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        chk("wr_data_mismatch", 64'(mismatch2), 64'd0);
        xfer2("wr_err", 12'h020, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("wr_err_mismatch", 64'(mismatch2), 64'd1);
        chk("wr_err_mask",     64'(mask2),     64'h2);
        cyc(); smp();
        chk("wr_err_mmcnt", 64'(mm_cnt2),   64'd2);
        chk("wr_err_ffa",   64'(ffa2),      64'h2C4);
        chk("wr_err_xfer",  64'(xfer_cnt2), 64'd4);

        // ---------------- request during REPORT is held off ----------------
        cyc(); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h040;
        cyc(); penable = 1'b1; rdy2 = 2'b11; prdata2 = {32'h77, 32'h77}; err2 = 2'b00;
        smp(); chk("b2b_first_pready", 64'(pready_o2), 64'd1);
        cyc(); paddr = 12'h044; prdata2 = {32'h88, 32'h99};
        smp();
        chk("b2b_report_cmp",    64'(cmp_valid2), 64'd1);
        chk("b2b_report_holdoff", 64'(pready_o2), 64'd0);
        cyc();
        smp();
        chk("b2b_idle_accept", 64'(pready_o2), 64'd1);
        chk("b2b_idle_xfer",   64'(xfer_cnt2), 64'd5);
        cyc(); psel = 1'b0; penable = 1'b0; rdy2 = 2'b00;
        smp();
        chk("b2b_second_cmp",  64'(cmp_valid2), 64'd1);
        chk("b2b_second_mask", 64'(mask2),      64'h2);
        cyc(); smp();
        chk("b2b_xfer",  64'(xfer_cnt2), 64'd6);
        chk("b2b_mmcnt", 64'(mm_cnt2),   64'd3);

        // ---------------- timeout: DUT1 never ready ----------------
        cyc(); psel = 1'b1; penable = 1'b0; paddr = 12'h3F0;
        cyc(); penable = 1'b1; rdy2 = 2'b01; prdata2 = {32'h0, 32'h55};
        smp(); chk("to_t0_pready", 64'(pready_o2), 64'd0);
        for (int k = 1; k <= 3; k++) begin
            cyc(); smp();
            chk($sformatf("to_t%0d_pready", k),  64'(pready_o2), 64'd0);
            chk($sformatf("to_t%0d_timeout", k), 64'(timeout2),  64'd0);
        end
        cyc(); smp();
        chk("to_t4_timeout", 64'(timeout2),  64'd1);
        chk("to_t4_forced",  64'(pready_o2), 64'd1);
        cyc(); psel = 1'b0; penable = 1'b0; rdy2 = 2'b00;
        smp();
        chk("to_cmp",      64'(cmp_valid2), 64'd1);
        chk("to_mismatch", 64'(mismatch2),  64'd1);
        chk("to_mask",     64'(mask2),      64'h2);
        chk("to_pulse_gone", 64'(timeout2), 64'd0);

        // ---------------- protocol abort: PSEL drops mid-collect ----------------
        cyc(); psel = 1'b1; penable = 1'b0; paddr = 12'h0AA;
        cyc(); penable = 1'b1; rdy2 = 2'b01;
        smp(); chk("pe_wait_pready", 64'(pready_o2), 64'd0);
        cyc(); psel = 1'b0; penable = 1'b0; rdy2 = 2'b00;
        smp(); chk("pe_pulse", 64'(proto_err2), 64'd1);
        cyc(); smp();
        chk("pe_cmp",  64'(cmp_valid2), 64'd1);
        chk("pe_mask", 64'(mask2),      64'h3);
        chk("pe_gone", 64'(proto_err2), 64'd0);
        cyc(); smp();
        chk("pe_xfer",  64'(xfer_cnt2), 64'd8);
        chk("pe_mmcnt", 64'(mm_cnt2),   64'd5);

        // ---------------- reset mid-transfer ----------------
        cyc(); psel = 1'b1; penable = 1'b0; paddr = 12'h0BB;
        cyc(); penable = 1'b1; rdy2 = 2'b01;
        cyc(); presetn = 1'b0; rdy2 = 2'b00;
        smp();
        chk("mr_outs", {pready_o2, cmp_valid2, mismatch2, mask2, timeout2, proto_err2, err_sticky2},
            64'd0);
        chk("mr_cnts", {xfer_cnt2, mm_cnt2, ffa2}, 64'd0);
        cyc(); psel = 1'b0; penable = 1'b0;
        cyc(); presetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(); smp();
            chk($sformatf("mr_no_cmp%0d", k), 64'(cmp_valid2), 64'd0);
        end

        // ---------------- 3 DUTs: DUT2 three cycles late ----------------
        cyc(); psel3 = 1'b1; penable3 = 1'b0; pwrite = 1'b0; paddr = 12'h123;
        cyc(); penable3 = 1'b1; rdy3 = 3'b011;
        prdata3 = {32'h1234_5678, 32'h1234_5678, 32'h1234_5678}; err3 = 3'b000;
        smp(); chk("sk3_t0_pready", 64'(pready_o3), 64'd0);
        cyc(); rdy3 = 3'b000;
        smp(); chk("sk3_t1_pready", 64'(pready_o3), 64'd0);
        cyc(); smp(); chk("sk3_t2_pready", 64'(pready_o3), 64'd0);
        cyc(); rdy3 = 3'b100;
        smp();
        chk("sk3_t3_pready",  64'(pready_o3), 64'd1);
        chk("sk3_t3_timeout", 64'(timeout3),  64'd0);
        cyc(); psel3 = 1'b0; penable3 = 1'b0; rdy3 = 3'b000;
        smp();
        chk("sk3_cmp",      64'(cmp_valid3), 64'd1);
        chk("sk3_mismatch", 64'(mismatch3),  64'd0);

        // ---------------- 3 DUTs: completion exactly at the skew limit ----------------
        cyc(); psel3 = 1'b1; penable3 = 1'b0; paddr = 12'h124;
        cyc(); penable3 = 1'b1; rdy3 = 3'b011;
        cyc(); rdy3 = 3'b000;
        cyc();
        cyc();
        smp(); chk("lim_t3_pready", 64'(pready_o3), 64'd0);
        cyc(); rdy3 = 3'b100;
        smp();
        chk("lim_t4_pready",  64'(pready_o3), 64'd1);
        chk("lim_t4_timeout", 64'(timeout3),  64'd0);
        cyc(); psel3 = 1'b0; penable3 = 1'b0; rdy3 = 3'b000;
        smp();
        chk("lim_cmp",      64'(cmp_valid3), 64'd1);
        chk("lim_mismatch", 64'(mismatch3),  64'd0);
        cyc(); smp();
        chk("sk3_xfer",  64'(xfer_cnt3), 64'd2);
        chk("sk3_mmcnt", 64'(mm_cnt3),   64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
